// File: rtl/pkt_check_sink_if.sv
// rtl/pkt_check_sink_if.sv - stream bundle feeding the packet check sink
//
// Purpose: groups the 512-bit packet stream handshake into one port.
// Signals:
//    tvalid  beat valid (master -> slave)
//    tready  sink ready (slave -> master)
//    tdata   512-bit beat payload
//    tlast   last beat of packet
//    tkeep   64 byte enables
interface pkt_check_sink_if;
   logic         tvalid;
   logic         tready;
   logic [511:0] tdata;
   logic         tlast;
   logic [63:0]  tkeep;

   modport master (output tvalid, output tdata, output tlast, output tkeep, input tready);
   modport slave  (input tvalid, input tdata, input tlast, input tkeep, output tready);
endinterface

// File: rtl/pkt_check_sink.sv
// rtl/pkt_check_sink.sv - packet length/keep checker and throughput meter
//
// Purpose: terminates a packet stream, checks each packet for the expected
// beat count and full byte enables, counts good and errored packets and
// measures accepted beats per fixed window.
// Ports:
//    clk          single clock, rising edge
//    rst          asynchronous active-low reset
//    test_mode    enables reception (IDLE <-> RX)
//    i_bp_en      enables one-in-four backpressure
//    s_axis       stream slave (tdata ignored)
//    o_thr_cnt    accepted beats in the last completed window
//    o_thr_valid  one-cycle pulse when o_thr_cnt is loaded
//    o_pkt_cnt    error-free packets, wraps
//    o_err_cnt    errored packets, saturates
//    o_err_len    sticky length-error flag
//    o_err_keep   sticky keep-error flag
module pkt_check_sink #(
   parameter int PKT_BEATS = 512,
   parameter int WINDOW    = 10000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  test_mode,
   input  logic                  i_bp_en,
   pkt_check_sink_if.slave       s_axis,
   output logic [13:0]           o_thr_cnt,
   output logic                  o_thr_valid,
   output logic [15:0]           o_pkt_cnt,
   output logic [15:0]           o_err_cnt,
   output logic                  o_err_len,
   output logic                  o_err_keep
);

   localparam logic [0:0]  ST_IDLE  = 1'b0;
   localparam logic [0:0]  ST_RX    = 1'b1;
   localparam logic [11:0] PKT_L    = 12'(PKT_BEATS);
   localparam logic [13:0] WIN_LAST = 14'(WINDOW - 1);

   logic [0:0]  state_q,    state_d;
   logic        tready_q,   tready_d;
   logic [1:0]  bp_q,       bp_d;
   logic [10:0] beat_cnt_q, beat_cnt_d;
   logic        perr_q,     perr_d;
   logic [15:0] pkt_cnt_q,  pkt_cnt_d;
   logic [15:0] err_cnt_q,  err_cnt_d;
   logic        err_len_q,  err_len_d;
   logic        err_keep_q, err_keep_d;
   logic [13:0] win_q,      win_d;
   logic [13:0] run_q,      run_d;
   logic [13:0] thr_cnt_q,  thr_cnt_d;
   logic        thr_vld_q,  thr_vld_d;

   logic        accept;
   logic [11:0] beat_num;
   logic        len_err;
   logic        keep_err;
   logic        pkt_err;
   logic        unused_tdata;

   assign unused_tdata = ^s_axis.tdata;

   always_comb begin
      state_d    = state_q;
      bp_d       = bp_q + 2'd1;
      beat_cnt_d = beat_cnt_q;
      perr_d     = perr_q;
      pkt_cnt_d  = pkt_cnt_q;
      err_cnt_d  = err_cnt_q;
      err_len_d  = err_len_q;
      err_keep_d = err_keep_q;
      win_d      = win_q + 14'd1;
      run_d      = run_q;
      thr_cnt_d  = thr_cnt_q;
      thr_vld_d  = 1'b0;

      // tready is only ever high in RX, so accept implies RX.
      accept   = s_axis.tvalid & tready_q;
      // Widened by one bit so a saturated counter cannot wrap to beat 0.
      beat_num = {1'b0, beat_cnt_q} + 12'd1;
      len_err  = accept & (s_axis.tlast ? (beat_num != PKT_L) : (beat_num > PKT_L));
      keep_err = accept & (s_axis.tkeep != {64{1'b1}});
      pkt_err  = perr_q | len_err | keep_err;

      if (accept) begin
         if (len_err)  err_len_d  = 1'b1;
         if (keep_err) err_keep_d = 1'b1;
         if (s_axis.tlast) begin
            // Exactly one count per packet; the last beat's own errors count.
            if (pkt_err) begin
               if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
            end else begin
               pkt_cnt_d = pkt_cnt_q + 16'd1;
            end
            beat_cnt_d = '0;
            perr_d     = 1'b0;
         end else begin
            if (beat_cnt_q != 11'h7FF) beat_cnt_d = beat_cnt_q + 11'd1;
            perr_d = pkt_err;
         end
      end

      case (state_q)
         ST_IDLE: begin
            if (test_mode) begin
               state_d    = ST_RX;
               err_len_d  = 1'b0;
               err_keep_d = 1'b0;
            end
         end
         default: begin
            // Leaving RX drops any partial packet silently.
            if (!test_mode) begin
               state_d    = ST_IDLE;
               beat_cnt_d = '0;
               perr_d     = 1'b0;
            end
         end
      endcase

      // Computed from next-state values so the registered tready lines up
      // with the state and bp phase it belongs to.
      tready_d = (state_d == ST_RX) & ~(i_bp_en & (bp_d == 2'd3));

      if (win_q == WIN_LAST) begin
         win_d     = '0;
         thr_cnt_d = run_q + {13'd0, accept};
         thr_vld_d = 1'b1;
         run_d     = '0;
      end else begin
         run_d = run_q + {13'd0, accept};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         tready_q   <= 1'b0;
         bp_q       <= '0;
         beat_cnt_q <= '0;
         perr_q     <= 1'b0;
         pkt_cnt_q  <= '0;
         err_cnt_q  <= '0;
         err_len_q  <= 1'b0;
         err_keep_q <= 1'b0;
         win_q      <= '0;
         run_q      <= '0;
         thr_cnt_q  <= '0;
         thr_vld_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         tready_q   <= tready_d;
         bp_q       <= bp_d;
         beat_cnt_q <= beat_cnt_d;
         perr_q     <= perr_d;
         pkt_cnt_q  <= pkt_cnt_d;
         err_cnt_q  <= err_cnt_d;
         err_len_q  <= err_len_d;
         err_keep_q <= err_keep_d;
         win_q      <= win_d;
         run_q      <= run_d;
         thr_cnt_q  <= thr_cnt_d;
         thr_vld_q  <= thr_vld_d;
      end
   end

   assign s_axis.tready = tready_q;
   assign o_thr_cnt     = thr_cnt_q;
   assign o_thr_valid   = thr_vld_q;
   assign o_pkt_cnt     = pkt_cnt_q;
   assign o_err_cnt     = err_cnt_q;
   assign o_err_len     = err_len_q;
   assign o_err_keep    = err_keep_q;

endmodule

// File: tb/tb_pkt_check_sink.sv
// tb/tb_pkt_check_sink.sv - randomized self-checking bench for pkt_check_sink
module tb_pkt_check_sink;
   localparam int PKT = 512;
   localparam int WIN = 10000;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        test_mode = 1'b0;
   logic        i_bp_en = 1'b0;
   logic [13:0] o_thr_cnt;
   logic        o_thr_valid;
   logic [15:0] o_pkt_cnt;
   logic [15:0] o_err_cnt;
   logic        o_err_len;
   logic        o_err_keep;

   pkt_check_sink_if s_axis();

   pkt_check_sink #(.PKT_BEATS(PKT), .WINDOW(WIN)) dut (
      .clk         (clk),
      .rst         (rst),
      .test_mode   (test_mode),
      .i_bp_en     (i_bp_en),
      .s_axis      (s_axis),
      .o_thr_cnt   (o_thr_cnt),
      .o_thr_valid (o_thr_valid),
      .o_pkt_cnt   (o_pkt_cnt),
      .o_err_cnt   (o_err_cnt),
      .o_err_len   (o_err_len),
      .o_err_keep  (o_err_keep)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;
   int thr_pulses = 0;
   int last_thr   = 0;
   int ready_low  = 0;

   // reference model state
   bit m_rx, m_ready, m_thrv, m_elen, m_ekeep, m_perr, m_acc;
   int m_bp, m_beats, m_pkt, m_errc, m_win, m_run, m_thr;

   task automatic finish_run();
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_rx = 0; m_ready = 0; m_thrv = 0; m_elen = 0; m_ekeep = 0; m_perr = 0; m_acc = 0;
      m_bp = 0; m_beats = 0; m_pkt = 0; m_errc = 0; m_win = 0; m_run = 0; m_thr = 0;
   endtask

   // One clock edge of the packet rules, evaluated on the inputs present at the edge.
   task automatic model_step();
      bit lerr, kerr, last;
      int bn;
      m_acc = s_axis.tvalid && m_ready;
      last  = s_axis.tlast;
      if (m_acc) begin
         bn   = m_beats + 1;
         lerr = last ? (bn != PKT) : (bn > PKT);
         kerr = (s_axis.tkeep !== {64{1'b1}});
         if (lerr) m_elen = 1;
         if (kerr) m_ekeep = 1;
         if (last) begin
            if (m_perr || lerr || kerr) m_errc = (m_errc < 65535) ? m_errc + 1 : 65535;
            else m_pkt = (m_pkt + 1) % 65536;
            m_beats = 0;
            m_perr  = 0;
         end else begin
            m_beats = bn;
            m_perr  = m_perr | lerr | kerr;
         end
      end
      if (!m_rx && test_mode) begin
         m_rx = 1; m_elen = 0; m_ekeep = 0;
      end else if (m_rx && !test_mode) begin
         m_rx = 0; m_beats = 0; m_perr = 0;
      end
      m_bp    = (m_bp + 1) % 4;
      m_ready = m_rx && !(i_bp_en && m_bp == 3);
      if (m_win == WIN - 1) begin
         m_thr = m_run + int'(m_acc); m_thrv = 1; m_run = 0; m_win = 0;
      end else begin
         m_run = m_run + int'(m_acc); m_thrv = 0; m_win = m_win + 1;
      end
   endtask

   task automatic compare_all();
      chk("tready",    32'(s_axis.tready), 32'(m_ready));
      chk("thr_valid", 32'(o_thr_valid),   32'(m_thrv));
      chk("thr_cnt",   32'(o_thr_cnt),     32'(m_thr));
      chk("pkt_cnt",   32'(o_pkt_cnt),     32'(m_pkt));
      chk("err_cnt",   32'(o_err_cnt),     32'(m_errc));
      chk("err_len",   32'(o_err_len),     32'(m_elen));
      chk("err_keep",  32'(o_err_keep),    32'(m_ekeep));
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_all();
      if (!s_axis.tready) ready_low++;
      if (o_thr_valid) begin thr_pulses++; last_thr = int'(o_thr_cnt); end
      if (n_err > 40) finish_run();
   endtask

   task automatic idle(input int n);
      s_axis.tvalid = 1'b0;
      s_axis.tlast  = 1'b0;
      s_axis.tkeep  = '1;
      repeat (n) tick();
   endtask

   // Offers beats until stop_after of them are accepted; tlast on beat len.
   task automatic run_pkt(input int len, input int keep_bad, input int gap, input int stop_after);
      int idx = 0;
      int cyc = 0;
      while (idx < stop_after && cyc < len * 10 + 500) begin
         s_axis.tvalid = (gap == 0) || ($urandom_range(0, 99) >= gap);
         s_axis.tlast  = (idx == len - 1);
         s_axis.tkeep  = (idx == keep_bad) ? 64'hFFFF_FFFF_FFFF_FFFE : {64{1'b1}};
         s_axis.tdata  = {16{$urandom}};
         tick();
         cyc++;
         if (m_acc) idx++;
      end
      chk("pkt_beats_done", 32'(idx), 32'(stop_after));
   endtask

   task automatic async_reset_check(input string tag);
      #2 rst = 1'b0;
      #1;
      chk({tag, "_tready"},   32'(s_axis.tready), 0);
      chk({tag, "_thr_cnt"},  32'(o_thr_cnt),     0);
      chk({tag, "_thr_vld"},  32'(o_thr_valid),   0);
      chk({tag, "_pkt_cnt"},  32'(o_pkt_cnt),     0);
      chk({tag, "_err_cnt"},  32'(o_err_cnt),     0);
      chk({tag, "_err_len"},  32'(o_err_len),     0);
      chk({tag, "_err_keep"}, 32'(o_err_keep),    0);
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      #1000000;
      n_checks++;
      n_err++;
      $display("FAIL watchdog: simulation time limit reached");
      finish_run();
   end

   initial begin
      int len, kb, gap, p0;
      s_axis.tvalid = 1'b0;
      s_axis.tlast  = 1'b0;
      s_axis.tkeep  = '1;
      s_axis.tdata  = '0;
      model_reset();

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      async_reset_check("reset");
      idle(2);

      // three clean back-to-back packets, no backpressure
      test_mode = 1'b1;
      idle(1);
      ready_low = 0;
      for (int i = 0; i < 3; i++) run_pkt(PKT, -1, 0, PKT);
      chk("clean_pkt_cnt", 32'(o_pkt_cnt), 3);
      chk("clean_err_cnt", 32'(o_err_cnt), 0);
      chk("clean_ready_low", 32'(ready_low), 0);

      // short packet then overrun packet
      run_pkt(500, -1, 0, 500);
      run_pkt(520, -1, 0, 520);
      chk("len_err_flag", 32'(o_err_len), 1);
      chk("len_err_cnt",  32'(o_err_cnt), 2);
      chk("len_pkt_cnt",  32'(o_pkt_cnt), 3);
      idle(3);

      // keep error plus bad length in one packet counts once
      async_reset_check("rst_b");
      idle(1);
      run_pkt(300, 10, 0, 300);
      chk("both_keep_flag", 32'(o_err_keep), 1);
      chk("both_len_flag",  32'(o_err_len), 1);
      chk("both_err_cnt",   32'(o_err_cnt), 1);

      // abort after 200 beats, re-enter RX, full packet is clean
      run_pkt(PKT, -1, 0, 200);
      idle(1);
      test_mode = 1'b0;
      idle(3);
      test_mode = 1'b1;
      idle(2);
      chk("reenter_len_clr",  32'(o_err_len), 0);
      chk("reenter_keep_clr", 32'(o_err_keep), 0);
      run_pkt(PKT, -1, 0, PKT);
      chk("abort_pkt_cnt", 32'(o_pkt_cnt), 1);
      chk("abort_err_cnt", 32'(o_err_cnt), 1);

      // reset mid-packet
      run_pkt(PKT, -1, 0, 100);
      async_reset_check("rst_mid");
      idle(2);

      // randomized traffic
      for (int p = 0; p < 10; p++) begin
         i_bp_en = 1'($urandom_range(0, 1));
         gap = $urandom_range(0, 30);
         len = ($urandom_range(0, 1) == 1) ? PKT : $urandom_range(PKT - 3, PKT + 3);
         kb  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len - 1) : -1;
         if ($urandom_range(0, 4) == 0) begin
            run_pkt(len, kb, gap, $urandom_range(1, len - 1));
            idle(1);
            test_mode = 1'b0;
            idle($urandom_range(1, 4));
            test_mode = 1'b1;
            idle(2);
         end else begin
            run_pkt(len, kb, gap, len);
            idle($urandom_range(0, 5));
         end
      end

      // throughput under periodic backpressure over a full window
      i_bp_en = 1'b1;
      p0 = thr_pulses;
      for (int k = 0; k < 40 && thr_pulses < p0 + 2; k++) run_pkt(PKT, -1, 0, PKT);
      chk("thr_two_pulses", 32'(thr_pulses >= p0 + 2), 1);
      chk("thr_bp_window",  32'(last_thr), 7500);
      idle(2);

      finish_run();
   end
endmodule
